// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encodings, opcode classes,
// datapath select codes and the control word driven by the decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EX_R   = 4'd2,
        ST_EX_I1  = 4'd3,
        ST_EX_I2  = 4'd4,
        ST_EX_LSW = 4'd5,
        ST_EX_B   = 4'd6,
        ST_EX_J   = 4'd7,
        ST_WB_ALU = 4'd8,
        ST_MEM_LW = 4'd9,
        ST_WB_LW  = 4'd10,
        ST_MEM_SW = 4'd11,
        ST_TRAP   = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_BR, CLS_J, CLS_I1, CLS_I2, CLS_LW, CLS_SW
    } op_class_e;

    localparam logic [2:0] ASB_REGB  = 3'b000;
    localparam logic [2:0] ASB_CONST = 3'b001;
    localparam logic [2:0] ASB_JOFF  = 3'b010;
    localparam logic [2:0] ASB_UIMM  = 3'b011;
    localparam logic [2:0] ASB_SEXT  = 3'b100;

    localparam logic [1:0] ADIR_ADD   = 2'b00;
    localparam logic [1:0] ADIR_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_src_a;
        logic       reg_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_dir;
        logic       mem_to_reg;
        logic       pc_write;
        logic       branch;
        logic       be;
        logic       trap;
    } ctrl_t;

    // Only the low four opcode bits carry meaning; anything above is illegal.
    function automatic logic is_legal_op(input logic [31:0] op);
        return op[31:4] == 28'd0;
    endfunction

    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1100, 4'b1011, 4'b1111:                   return CLS_R;
            4'b0100, 4'b0101:                                     return CLS_BR;
            4'b0011:                                              return CLS_J;
            4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: return CLS_I1;
            4'b0000:                                              return CLS_I2;
            4'b0001:                                              return CLS_LW;
            default:                                              return CLS_SW;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the current state; FETCH gates its
// IR/PC writes on mem_ready, DECODE sets register selects for loads/stores.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   op0_i,
    input  logic   lsw_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ASB_CONST;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.reg_dst   = lsw_i;
                ctrl_o.reg_src_a = lsw_i;
            end
            ST_EX_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_dir   = ADIR_FUNCT;
            end
            ST_EX_I1: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_SEXT;
                ctrl_o.alu_dir   = ADIR_FUNCT;
            end
            ST_EX_I2: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_UIMM;
                ctrl_o.alu_dir   = ADIR_FUNCT;
            end
            ST_EX_LSW: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_SEXT;
                ctrl_o.alu_dir   = ADIR_ADD;
            end
            ST_EX_B: begin
                ctrl_o.pc_src = PCSRC_BRANCH;
                ctrl_o.branch = 1'b1;
                ctrl_o.be     = ~op0_i;
            end
            ST_EX_J: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = ASB_JOFF;
            end
            ST_WB_ALU: ctrl_o.reg_write = 1'b1;
            ST_MEM_LW: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            ST_WB_LW: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_SW: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_TRAP:   ctrl_o.trap = 1'b1;
            default:   ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM with memory-wait watchdog and sticky trap state.
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int ALUSRCB_W   = 3,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 16
`ifdef MC_CTRL_PERF_CNT_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic                 mem_ready,
    output logic [1:0]           pc_src,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 reg_src_a,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [ALUSRCB_W-1:0] alu_src_b,
    output logic [1:0]           alu_dir,
    output logic                 mem_to_reg,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 be,
    output logic                 trap,
    output logic [3:0]           state_o
`ifdef MC_CTRL_PERF_CNT_EN
    , output logic [CNT_W-1:0]   instr_retired
    , output logic [CNT_W-1:0]   wait_cycles
`endif
);

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            op0_q, op0_d;
    logic            legal, lsw, timeout, wait_inc;
    op_class_e       cls;
    ctrl_t           ctrl;

    assign legal   = is_legal_op(32'(op));
    assign cls     = op_class(op[3:0]);
    assign lsw     = legal && (cls == CLS_LW || cls == CLS_SW);
    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
                       else if (timeout) state_d = ST_TRAP;
            ST_DECODE: begin
                // Branch sense is captured here so later op changes cannot disturb EX_B.
                op0_d = op[0];
                if (!legal) begin
                    state_d = ST_TRAP;
                end else begin
                    case (cls)
                        CLS_R:   state_d = ST_EX_R;
                        CLS_BR:  state_d = ST_EX_B;
                        CLS_J:   state_d = ST_EX_J;
                        CLS_I1:  state_d = ST_EX_I1;
                        CLS_I2:  state_d = ST_EX_I2;
                        default: state_d = ST_EX_LSW;
                    endcase
                end
            end
            ST_EX_R, ST_EX_I1, ST_EX_I2: state_d = ST_WB_ALU;
            ST_EX_LSW: state_d = op[0] ? ST_MEM_LW : ST_MEM_SW;
            ST_EX_B, ST_EX_J, ST_WB_ALU, ST_WB_LW: state_d = ST_FETCH;
            ST_MEM_LW: if (mem_ready) state_d = ST_WB_LW;
                       else if (timeout) state_d = ST_TRAP;
            ST_MEM_SW: if (mem_ready) state_d = ST_FETCH;
                       else if (timeout) state_d = ST_TRAP;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    assign wait_inc = (state_q == ST_FETCH || state_q == ST_MEM_LW || state_q == ST_MEM_SW)
                      && !mem_ready && (state_d == state_q);

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (wait_inc && wait_q != '1)
            wait_d = wait_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            op0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op0_q   <= op0_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .op0_i       (op0_q),
        .lsw_i       (lsw),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_src_a  = ctrl.reg_src_a;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ALUSRCB_W'(ctrl.alu_src_b);
    assign alu_dir    = ctrl.alu_dir;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign be         = ctrl.be;
    assign trap       = ctrl.trap;
    assign state_o    = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, waits_q;
    logic             retire;

    assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            waits_q   <= '0;
        end else begin
            if (retire && retired_q != '1)
                retired_q <= retired_q + CNT_W'(1);
            if (wait_inc && waits_q != '1)
                waits_q <= waits_q + CNT_W'(1);
        end
    end

    assign instr_retired = retired_q;
    assign wait_cycles   = waits_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, multi-cycle corner sequences,
// then random traffic against an instruction-path reference model.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int OP_W = 5;
    localparam int TOUT = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [OP_W-1:0] op = '0;
    logic            mem_ready = 1'b0;
    logic [1:0]      pc_src, alu_dir;
    logic [2:0]      alu_src_b;
    logic [3:0]      state_o;
    logic iord, mem_read, mem_write, ir_write, reg_dst, reg_src_a, reg_write;
    logic alu_src_a, mem_to_reg, pc_write, branch, be, trap;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] instr_retired, wait_cycles;
`endif

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.OP_W(OP_W), .ALUSRCB_W(3), .TO_W(8), .MEM_TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_src_a(reg_src_a),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_dir(alu_dir), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
        .branch(branch), .be(be), .trap(trap), .state_o(state_o)
`ifdef MC_CTRL_PERF_CNT_EN
        , .instr_retired(instr_retired), .wait_cycles(wait_cycles)
`endif
    );

    typedef struct packed {
        logic [1:0] pc_src;
        logic iord, mem_read, mem_write, ir_write, reg_dst, reg_src_a, reg_write, alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_dir;
        logic mem_to_reg, pc_write, branch, be, trap;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        logic            rst;
        logic [OP_W-1:0] op;
        logic            rdy;
        obs_t            exp;
    } vec_t;

    obs_t obs;
    assign obs = {pc_src, iord, mem_read, mem_write, ir_write, reg_dst, reg_src_a,
                  reg_write, alu_src_a, alu_src_b, alu_dir, mem_to_reg, pc_write,
                  branch, be, trap, state_o};

    int n_chk = 0;
    int n_pass = 0;

    // Expected control word for each state, straight from the control table.
    function automatic obs_t exp_out(state_e s, logic rdy, logic lsw, logic bee);
        obs_t o = '0;
        o.st = s;
        case (s)
            ST_FETCH:  begin o.mem_read = 1'b1; o.alu_src_b = 3'b001; o.ir_write = rdy; o.pc_write = rdy; end
            ST_DECODE: begin o.reg_dst = lsw; o.reg_src_a = lsw; end
            ST_EX_R:   begin o.alu_src_a = 1'b1; o.alu_dir = 2'b10; end
            ST_EX_I1:  begin o.alu_src_a = 1'b1; o.alu_src_b = 3'b100; o.alu_dir = 2'b10; end
            ST_EX_I2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 3'b011; o.alu_dir = 2'b10; end
            ST_EX_LSW: begin o.alu_src_a = 1'b1; o.alu_src_b = 3'b100; end
            ST_EX_B:   begin o.pc_src = 2'b01; o.branch = 1'b1; o.be = bee; end
            ST_EX_J:   begin o.pc_write = 1'b1; o.alu_src_b = 3'b010; end
            ST_WB_ALU: o.reg_write = 1'b1;
            ST_MEM_LW: begin o.iord = 1'b1; o.mem_read = 1'b1; end
            ST_WB_LW:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            ST_MEM_SW: begin o.iord = 1'b1; o.mem_write = 1'b1; end
            ST_TRAP:   o.trap = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic vec_t mkv(logic r, logic [OP_W-1:0] o, logic rd, obs_t e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = rd; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (state got=%0d expected=%0d)",
                      name, got, exp, got.st, exp.st);
    endtask

    task automatic cycle(input logic r, input logic [OP_W-1:0] o, input logic rd, output obs_t got);
        reset = r; op = o; mem_ready = rd;
        @(negedge clk);
        got = obs;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input logic r, input logic [OP_W-1:0] o,
                       input logic rd, input obs_t exp);
        obs_t g;
        cycle(r, o, rd, g);
        check(name, g, exp);
    endtask

    // ---------------- reference model: per-instruction state path ----------------
    state_e m_st;
    state_e m_path[$];
    int     m_w;
    logic   m_be;

    function automatic int cls_of(logic [OP_W-1:0] o);
        logic [3:0] lo;
        if (o > 15) return -1;
        lo = o[3:0];
        case (lo)
            4'd8, 4'd12, 4'd11, 4'd15:                 return 0;
            4'd4, 4'd5:                                return 1;
            4'd3:                                      return 2;
            4'd9, 4'd10, 4'd13, 4'd14, 4'd7, 4'd6:     return 3;
            4'd0:                                      return 4;
            default:                                   return 5;
        endcase
    endfunction

    task automatic m_advance();
        m_w = 0;
        if (m_path.size() == 0) m_st = ST_FETCH;
        else m_st = m_path.pop_front();
    endtask

    task automatic model_step(input logic r, input logic [OP_W-1:0] o, input logic rd);
        if (r) begin
            m_st = ST_FETCH; m_w = 0; m_path.delete();
        end else if (m_st == ST_TRAP) begin
            m_st = ST_TRAP;
        end else if ((m_st == ST_FETCH || m_st == ST_MEM_LW || m_st == ST_MEM_SW) && !rd) begin
            if (m_w == TOUT) begin m_st = ST_TRAP; m_w = 0; m_path.delete(); end
            else if (m_w < 255) m_w++;
        end else if (m_st == ST_FETCH) begin
            m_w = 0; m_st = ST_DECODE;
        end else if (m_st == ST_DECODE) begin
            m_be = ~o[0];
            case (cls_of(o))
                -1: m_path = '{ST_TRAP};
                0:  m_path = '{ST_EX_R, ST_WB_ALU};
                1:  m_path = '{ST_EX_B};
                2:  m_path = '{ST_EX_J};
                3:  m_path = '{ST_EX_I1, ST_WB_ALU};
                4:  m_path = '{ST_EX_I2, ST_WB_ALU};
                default: m_path = '{ST_EX_LSW};
            endcase
            m_advance();
        end else if (m_st == ST_EX_LSW) begin
            if (o == 1) m_path = '{ST_MEM_LW, ST_WB_LW};
            else        m_path = '{ST_MEM_SW};
            m_advance();
        end else begin
            m_advance();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[$];
        obs_t g;
        int   stall;
        int   tcnt;

        cycle(1'b1, 5'd0, 1'b0, g);
        cycle(1'b1, 5'd0, 1'b0, g);

        // Directed table, mem_ready held high except the first reset-state row.
        vt.push_back(mkv(1'b0, 5'd0, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd8, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd8, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd8, 1'b1, exp_out(ST_EX_R, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd8, 1'b1, exp_out(ST_WB_ALU, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd4, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd4, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd5, 1'b1, exp_out(ST_EX_B, 1'b1, 1'b0, 1'b1)));
        vt.push_back(mkv(1'b0, 5'd5, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd5, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd4, 1'b1, exp_out(ST_EX_B, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd3, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd3, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd3, 1'b1, exp_out(ST_EX_J, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd0, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd0, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd0, 1'b1, exp_out(ST_EX_I2, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd0, 1'b1, exp_out(ST_WB_ALU, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd9, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd9, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd9, 1'b1, exp_out(ST_EX_I1, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd9, 1'b1, exp_out(ST_WB_ALU, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd2, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd2, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b1, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd2, 1'b1, exp_out(ST_EX_LSW, 1'b1, 1'b0, 1'b0)));
        vt.push_back(mkv(1'b0, 5'd2, 1'b1, exp_out(ST_MEM_SW, 1'b1, 1'b0, 1'b0)));
        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].op, vt[i].rdy, g);
            check($sformatf("vec%0d", i), g, vt[i].exp);
        end

        // LW with three wait cycles: 8 cycles from FETCH to the next FETCH.
        run("lw_fetch", 1'b0, 5'd1, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0));
        run("lw_decode", 1'b0, 5'd1, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b1, 1'b0));
        run("lw_ex", 1'b0, 5'd1, 1'b1, exp_out(ST_EX_LSW, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            run("lw_wait", 1'b0, 5'd1, 1'b0, exp_out(ST_MEM_LW, 1'b0, 1'b0, 1'b0));
        run("lw_mem", 1'b0, 5'd1, 1'b1, exp_out(ST_MEM_LW, 1'b1, 1'b0, 1'b0));
        run("lw_wb", 1'b0, 5'd1, 1'b1, exp_out(ST_WB_LW, 1'b1, 1'b0, 1'b0));
        run("lw_done", 1'b0, 5'd0, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0));

        // mem_ready arriving exactly at the timeout count wins over the trap.
        cycle(1'b1, 5'd0, 1'b0, g);
        for (int i = 0; i < TOUT; i++)
            run("rdy_wins_wait", 1'b0, 5'd3, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0));
        run("rdy_wins_last", 1'b0, 5'd3, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0));
        run("rdy_wins_dec", 1'b0, 5'd3, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0));
        run("rdy_wins_j", 1'b0, 5'd3, 1'b1, exp_out(ST_EX_J, 1'b1, 1'b0, 1'b0));

        // Watchdog expiry in FETCH: trap after TOUT+1 wait cycles, sticky until reset.
        for (int i = 0; i <= TOUT; i++)
            run("to_wait", 1'b0, 5'd0, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0));
        run("to_trap", 1'b0, 5'd0, 1'b1, exp_out(ST_TRAP, 1'b1, 1'b0, 1'b0));
        run("to_sticky", 1'b0, 5'd8, 1'b1, exp_out(ST_TRAP, 1'b1, 1'b0, 1'b0));
        run("to_reset", 1'b1, 5'd0, 1'b1, exp_out(ST_TRAP, 1'b1, 1'b0, 1'b0));
        run("to_clear", 1'b0, 5'd0, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0));

        // Opcode with bit 4 set is illegal.
        cycle(1'b1, 5'd0, 1'b0, g);
        run("ill_fetch", 1'b0, 5'd16, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0));
        run("ill_decode", 1'b0, 5'd16, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b0, 1'b0));
        run("ill_trap", 1'b0, 5'd16, 1'b1, exp_out(ST_TRAP, 1'b1, 1'b0, 1'b0));
        run("ill_trap2", 1'b0, 5'd1, 1'b1, exp_out(ST_TRAP, 1'b1, 1'b0, 1'b0));

        // Reset in the middle of a store wait aborts the write.
        cycle(1'b1, 5'd0, 1'b0, g);
        run("sw_fetch", 1'b0, 5'd2, 1'b1, exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0));
        run("sw_dec", 1'b0, 5'd2, 1'b1, exp_out(ST_DECODE, 1'b1, 1'b1, 1'b0));
        run("sw_ex", 1'b0, 5'd2, 1'b1, exp_out(ST_EX_LSW, 1'b1, 1'b0, 1'b0));
        run("sw_wait", 1'b0, 5'd2, 1'b0, exp_out(ST_MEM_SW, 1'b0, 1'b0, 1'b0));
        run("sw_rst", 1'b1, 5'd2, 1'b0, exp_out(ST_MEM_SW, 1'b0, 1'b0, 1'b0));
`ifdef MC_CTRL_PERF_CNT_EN
        n_chk++;
        if (instr_retired === 32'd0 && wait_cycles === 32'd0) n_pass++;
        else $display("FAIL perf_reset: instr_retired=%0d wait_cycles=%0d expected 0 and 0",
                      instr_retired, wait_cycles);
`endif
        run("sw_abort", 1'b0, 5'd2, 1'b0, exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0));

        // Random traffic against the path model.
        cycle(1'b1, 5'd0, 1'b0, g);
        model_step(1'b1, 5'd0, 1'b0);
        m_be = 1'b0;
        stall = 0;
        tcnt = 0;
        for (int n = 0; n < 1500; n++) begin
            logic            r, rd, lsw;
            logic [OP_W-1:0] o;
            obs_t            e;
            r = (m_st == ST_TRAP && tcnt > 2) || ($urandom_range(0, 59) == 0);
            if (m_st == ST_EX_LSW)               o = OP_W'($urandom_range(1, 2));
            else if ($urandom_range(0, 19) == 0) o = OP_W'($urandom_range(16, 31));
            else                                 o = OP_W'($urandom_range(0, 15));
            if (stall == 0 && $urandom_range(0, 29) == 0) stall = int'($urandom_range(1, 7));
            if (stall > 0) begin rd = 1'b0; stall--; end
            else rd = ($urandom_range(0, 3) != 0);
            lsw = (o == 1) || (o == 2);
            e = exp_out(m_st, rd, lsw, m_be);
            cycle(r, o, rd, g);
            check("rand", g, e);
            model_step(r, o, rd);
            tcnt = (m_st == ST_TRAP) ? tcnt + 1 : 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
